// File: rtl/sd_spi_shifter.sv
// Byte-wide SPI mode-0 master shifter for the SD card port.
// It drives sck/sdo, samples sdi on the edge that ends each sck-high phase, and reports busy/done.
module sd_spi_shifter #(
  parameter logic       SDO_IDLE = 1'b1,
  parameter logic [7:0] DOUT_RST = 8'hFF
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [1:0] speed,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state_q;
  logic [2:0] hm1_q;
  logic [2:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic       sck_q;
  logic       sdo_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] dout_q;

  logic [2:0] hm1_d;
  logic [7:0] rx_d;

  // hm1 is the half-period minus one, so the phase counter fits in three bits.
  always_comb begin
    hm1_d = 3'd0;
    case (speed)
      2'b00:   hm1_d = 3'd0;
      2'b01:   hm1_d = 3'd1;
      2'b10:   hm1_d = 3'd3;
      default: hm1_d = 3'd7;
    endcase
  end

  assign rx_d = {rx_q[6:0], sdi};

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      hm1_q   <= 3'd0;
      cnt_q   <= 3'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      sck_q   <= 1'b0;
      sdo_q   <= SDO_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= DOUT_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            tx_q    <= din;
            sdo_q   <= din[7];
            hm1_q   <= hm1_d;
            cnt_q   <= 3'd0;
            bit_q   <= 3'd0;
            sck_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q != hm1_q) begin
            cnt_q <= cnt_q + 3'd1;
          end else begin
            cnt_q <= 3'd0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // Falling sck edge: capture sdi, then either present the next bit or finish.
              sck_q <= 1'b0;
              rx_q  <= rx_d;
              if (bit_q == 3'd7) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                dout_q  <= rx_d;
                sdo_q   <= SDO_IDLE;
              end else begin
                bit_q <= bit_q + 3'd1;
                tx_q  <= {tx_q[6:0], 1'b0};
                sdo_q <= tx_q[6];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sck         = sck_q;
  assign sdo         = sdo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dout        = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Bench for sd_spi_shifter: a card model answers on sdi, a monitor rebuilds each byte from the
// observed sck/sdo/busy waveform and compares it against expectations queued by the driver.
module tb_sd_spi_shifter;

  logic       fclk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [1:0] speed;
  logic       sck;
  logic       sdo;
  logic       sdi;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       dbg_state_o;

  int vectors     = 0;
  int miscompares = 0;

  // Each entry: {tx byte[19:12], half-period H[11:8], card byte[7:0]}
  logic [19:0] exp_q[$];

  sd_spi_shifter dut (
    .fclk        (fclk),
    .rst         (rst),
    .start       (start),
    .din         (din),
    .speed       (speed),
    .sck         (sck),
    .sdo         (sdo),
    .sdi         (sdi),
    .dout        (dout),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- card model: presents MSB first, shifts on sck fall ----------------
  logic [7:0] card_next;
  logic [7:0] card_cur;
  int         card_idx;
  logic       prev_sck_c;
  logic       prev_busy_c;

  always @(negedge fclk) begin
    if (rst) begin
      prev_sck_c  = 1'b0;
      prev_busy_c = 1'b0;
    end else begin
      if (busy && !prev_busy_c) begin
        card_cur = card_next;
        card_idx = 0;
        sdi      = card_next[7];
      end else if (busy && prev_sck_c && !sck) begin
        card_idx++;
        if (card_idx < 8) sdi = card_cur[7-card_idx];
      end
      prev_sck_c  = sck;
      prev_busy_c = busy;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  mod_dout;
  int          busy_len;
  int          run_len;
  int          runs_q[$];
  logic        run_lvl;
  logic        first_lvl;
  logic [7:0]  bits;
  logic [7:0]  nbits;
  logic        prev_busy_m;
  logic        prev_done_m;
  logic [19:0] e;
  int          h;
  logic        runs_ok;

  always @(negedge fclk) begin
    if (rst) begin
      mod_dout    = 8'hFF;
      prev_busy_m = 1'b0;
      prev_done_m = 1'b0;
      runs_q.delete();
    end else begin
      check("done_exclusive", {31'd0, done && (busy || prev_done_m)}, 32'd0);
      if (busy) begin
        if (!prev_busy_m) begin
          check("dout_hold", {24'd0, dout}, {24'd0, mod_dout});
          busy_len  = 1;
          run_lvl   = sck;
          first_lvl = sck;
          run_len   = 1;
          bits      = 8'h00;
          nbits     = 8'd0;
          runs_q.delete();
        end else begin
          busy_len++;
          if (sck == run_lvl) begin
            run_len++;
          end else begin
            runs_q.push_back(run_len);
            run_lvl = sck;
            run_len = 1;
            if (sck) begin
              bits  = {bits[6:0], sdo};
              nbits = nbits + 8'd1;
            end
          end
        end
      end else begin
        check("idle_lines", {30'd0, sck, sdo}, {30'd0, 1'b0, 1'b1});
        if (done) begin
          check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            h = int'(e[11:8]);
            runs_q.push_back(run_len);
            check("dout", {24'd0, dout}, {24'd0, e[7:0]});
            mod_dout = e[7:0];
            check("busy_len", busy_len, 16 * h);
            check("sdo_bits", {16'd0, nbits, bits}, {16'd0, 8'd8, e[19:12]});
            runs_ok = (runs_q.size() == 16) && (first_lvl == 1'b0);
            foreach (runs_q[i]) if (runs_q[i] != h) runs_ok = 1'b0;
            check("sck_timing", {31'd0, runs_ok}, 32'd1);
          end
        end
      end
      prev_busy_m = busy;
      prev_done_m = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  // Issues one byte and returns in its done cycle, so an immediate next send is back-to-back.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [7:0] card,
                      input int stray_at, input logic stray_start,
                      input logic [7:0] stray_din, input logic [1:0] stray_spd);
    int hh;
    hh        = 1 << s;
    card_next = card;
    din       = d;
    speed     = s;
    start     = 1'b1;
    @(posedge fclk);
    #1;
    start = 1'b0;
    exp_q.push_back({d, 4'(hh), card});
    for (int c = 1; c <= 16 * hh; c++) begin
      if (c == stray_at) begin
        speed = stray_spd;
        din   = stray_din;
        start = stray_start;
      end
      @(posedge fclk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic reset_mid_byte(input logic [7:0] d, input logic [7:0] card);
    card_next = card;
    din       = d;
    speed     = 2'b01;
    start     = 1'b1;
    @(posedge fclk);
    #1;
    start = 1'b0;
    exp_q.push_back({d, 4'd2, card});
    for (int c = 1; c < 7; c++) begin
      @(posedge fclk);
      #1;
    end
    rst = 1'b1;
    @(posedge fclk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_sdo", {31'd0, sdo}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'h0000_00FF);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rd;
    logic [1:0] rs;
    int         rh;
    rst   = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    speed = 2'b00;
    sdi   = 1'b1;
    card_next = 8'hFF;
    repeat (3) @(posedge fclk);
    #1;
    check("init_sck", {31'd0, sck}, 32'd0);
    check("init_sdo", {31'd0, sdo}, 32'd1);
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_done", {31'd0, done}, 32'd0);
    check("init_dout", {24'd0, dout}, 32'h0000_00FF);
    rst = 1'b0;
    idle(2);

    send(8'hA5, 2'b00, 8'h3C, 0, 1'b0, 8'h00, 2'b00);
    idle(2);
    send(8'h00, 2'b11, 8'hFF, 0, 1'b0, 8'h00, 2'b11);
    idle(1);
    send(8'hAA, 2'b00, 8'h96, 0, 1'b0, 8'h00, 2'b00);
    send(8'h55, 2'b00, 8'h0F, 5, 1'b1, 8'h12, 2'b00);
    idle(2);
    send(8'h81, 2'b00, 8'h7E, 3, 1'b0, 8'h00, 2'b11);
    send(8'h6D, 2'b11, 8'hB2, 0, 1'b0, 8'h00, 2'b11);
    idle(3);
    reset_mid_byte(8'hE7, 8'h5A);
    idle(2);
    send(8'hC3, 2'b01, 8'h24, 0, 1'b0, 8'h00, 2'b01);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 5));
      rd = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      rh = 1 << rs;
      send(rd, rs, 8'($urandom), $urandom_range(0, 16 * rh), 1'($urandom),
           8'($urandom), 2'($urandom_range(0, 3)));
    end

    idle(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
